// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master/slave loopback fixture.
package spi_pkg;

  localparam int BYTE_W = 8;
  localparam int BIT_CNT_W = $clog2(BYTE_W);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    DONE
  } state_e;

endpackage

// File: rtl/spi_master_slave_if.sv
// Host-side and serial-side signals of the SPI loopback fixture.
// The host drives through the master modport; the fixture implements the slave modport.
interface spi_master_slave_if;
  import spi_pkg::*;

  logic              start;
  logic              sel;
  logic [BYTE_W-1:0] tx_data;
  logic [BYTE_W-1:0] rx_data;
  logic              busy;
  logic              done;
  logic [BYTE_W-1:0] slv0_tx_data;
  logic [BYTE_W-1:0] slv1_tx_data;
  logic [BYTE_W-1:0] slv0_rx_data;
  logic              slv0_rx_valid;
  logic [BYTE_W-1:0] slv1_rx_data;
  logic              slv1_rx_valid;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic              ss0;
  logic              ss1;

  modport master (
    output start, sel, tx_data, slv0_tx_data, slv1_tx_data,
    input  rx_data, busy, done, slv0_rx_data, slv0_rx_valid,
    input  slv1_rx_data, slv1_rx_valid, sclk, mosi, miso, ss0, ss1
  );

  modport slave (
    input  start, sel, tx_data, slv0_tx_data, slv1_tx_data,
    output rx_data, busy, done, slv0_rx_data, slv0_rx_valid,
    output slv1_rx_data, slv1_rx_valid, sclk, mosi, miso, ss0, ss1
  );

endinterface

// File: rtl/spi_slave_if.sv
// Mode-0 SPI slave, oversampling sclk/ss with the system clock.
module spi_slave_if
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_i,
  input  logic              ss_i,
  input  logic              mosi_i,
  input  logic [BYTE_W-1:0] tx_data_i,
  output logic              miso_o,
  output logic [BYTE_W-1:0] rx_data_o,
  output logic              rx_valid_o
);

  logic                 sclk_q;
  logic                 ss_q;
  logic [BYTE_W-1:0]    tx_sr_q;
  logic [BYTE_W-1:0]    rx_sr_q;
  logic [BIT_CNT_W-1:0] cnt_q;
  logic                 miso_q;
  logic [BYTE_W-1:0]    rx_data_q;
  logic                 rx_valid_q;

  logic ss_fall, sclk_rise, sclk_fall;
  assign ss_fall   = ss_q & ~ss_i;
  assign sclk_rise = ~sclk_q & sclk_i;
  assign sclk_fall = sclk_q & ~sclk_i;

  // NOTE: ss_q resets to the idle (high) level so the first real select is seen as a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_q     <= 1'b0;
      ss_q       <= 1'b1;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      cnt_q      <= '0;
      miso_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      sclk_q     <= sclk_i;
      ss_q       <= ss_i;
      rx_valid_q <= 1'b0;
      if (ss_i) begin
        miso_q <= 1'b0;
      end else if (ss_fall) begin
        tx_sr_q <= tx_data_i;
        miso_q  <= tx_data_i[BYTE_W-1];
        cnt_q   <= '0;
      end else if (sclk_rise) begin
        rx_sr_q <= {rx_sr_q[BYTE_W-2:0], mosi_i};
        cnt_q   <= cnt_q + 1'b1;
        if (cnt_q == BIT_CNT_W'(BYTE_W - 1)) begin
          rx_data_q  <= {rx_sr_q[BYTE_W-2:0], mosi_i};
          rx_valid_q <= 1'b1;
        end
      end else if (sclk_fall) begin
        tx_sr_q <= {tx_sr_q[BYTE_W-2:0], 1'b0};
        miso_q  <= tx_sr_q[BYTE_W-2];
      end
    end
  end

  assign miso_o     = miso_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;

endmodule

// File: rtl/spi_master_slave.sv
// SPI master (mode 0, MSB first) driving two spi_slave_if instances on shared sclk/mosi.
// Frame: SETUP, 16 sclk half-periods, HOLD, then a one-cycle DONE.
module spi_master_slave
  import spi_pkg::*;
#(
  parameter int SCLK_HALF = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_master_slave_if.slave     bus
);

  localparam logic [7:0] HALF_LAST = 8'(SCLK_HALF - 1);

  state_e            state_q;
  logic [7:0]        cnt_q;
  logic [3:0]        half_q;
  logic [BYTE_W-1:0] tx_q;
  logic [BYTE_W-1:0] rx_q;
  logic [BYTE_W-1:0] rx_data_q;
  logic              busy_q;
  logic              done_q;
  logic              sclk_q;
  logic              mosi_q;
  logic              ss0_q;
  logic              ss1_q;

  logic miso, miso0, miso1;
  logic half_end;
  assign half_end = (cnt_q == HALF_LAST);

  // NOTE: all state uses non-blocking assignments so every register sees the pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      half_q    <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      ss0_q     <= 1'b1;
      ss1_q     <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          // busy_q is still high during the done cycle, so a start there is dropped.
          if (bus.start && !busy_q) begin
            busy_q  <= 1'b1;
            tx_q    <= bus.tx_data;
            mosi_q  <= bus.tx_data[BYTE_W-1];
            ss0_q   <= bus.sel;
            ss1_q   <= ~bus.sel;
            cnt_q   <= '0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (half_end) begin
            cnt_q   <= '0;
            half_q  <= '0;
            sclk_q  <= 1'b1;
            rx_q    <= {rx_q[BYTE_W-2:0], miso};
            state_q <= XFER;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        XFER: begin
          if (half_end) begin
            cnt_q <= '0;
            if (half_q == 4'd15) begin
              state_q <= HOLD;
            end else begin
              half_q <= half_q + 1'b1;
              sclk_q <= ~sclk_q;
              if (sclk_q) begin
                // Zeros shift in behind the data, so the 8th fall leaves mosi low.
                mosi_q <= tx_q[BYTE_W-2];
                tx_q   <= {tx_q[BYTE_W-2:0], 1'b0};
              end else begin
                rx_q <= {rx_q[BYTE_W-2:0], miso};
              end
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (half_end) begin
            cnt_q   <= '0;
            ss0_q   <= 1'b1;
            ss1_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          done_q    <= 1'b1;
          rx_data_q <= rx_q;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  spi_slave_if u_slv0 (
    .clk        (clk),
    .rst        (rst),
    .sclk_i     (sclk_q),
    .ss_i       (ss0_q),
    .mosi_i     (mosi_q),
    .tx_data_i  (bus.slv0_tx_data),
    .miso_o     (miso0),
    .rx_data_o  (bus.slv0_rx_data),
    .rx_valid_o (bus.slv0_rx_valid)
  );

  spi_slave_if u_slv1 (
    .clk        (clk),
    .rst        (rst),
    .sclk_i     (sclk_q),
    .ss_i       (ss1_q),
    .mosi_i     (mosi_q),
    .tx_data_i  (bus.slv1_tx_data),
    .miso_o     (miso1),
    .rx_data_o  (bus.slv1_rx_data),
    .rx_valid_o (bus.slv1_rx_valid)
  );

  assign miso = !ss0_q ? miso0 : (!ss1_q ? miso1 : 1'b0);

  assign bus.miso    = miso;
  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.ss0     = ss0_q;
  assign bus.ss1     = ss1_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master_slave.sv
// Self-checking bench for spi_master_slave: directed table, corner sequences, random frames.
module tb_spi_master_slave;
  import spi_pkg::*;

  localparam int HALF = 2;
  localparam int LAT  = 18 * HALF + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_master_slave_if bus ();

  spi_master_slave #(.SCLK_HALF(HALF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: the last byte each slave has fully received.
  logic [7:0] m_slv [2];

  typedef struct {
    int lat;
    int rises;
    int v0;
    int v1;
    bit ss0_low;
    bit ss1_low;
    bit both_low;
    bit gap_ok;
    bit timeout;
  } stat_t;

  typedef struct {
    logic       sel;
    logic [7:0] tx;
    logic [7:0] r0;
    logic [7:0] r1;
    logic [7:0] exp_rx;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input logic sel, input logic [7:0] tx, input logic [7:0] r0,
                           input logic [7:0] r1, input int inject_at, output stat_t st);
    logic prev_sclk;
    st = '{default: 0};
    @(negedge clk);
    st.gap_ok = bus.ss0 && bus.ss1;
    bus.slv0_tx_data = r0;
    bus.slv1_tx_data = r1;
    bus.sel          = sel;
    bus.tx_data      = tx;
    bus.start        = 1'b1;
    prev_sclk        = bus.sclk;
    st.timeout       = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.sclk && !prev_sclk) st.rises++;
      prev_sclk = bus.sclk;
      if (bus.slv0_rx_valid) st.v0++;
      if (bus.slv1_rx_valid) st.v1++;
      if (!bus.ss0) st.ss0_low = 1'b1;
      if (!bus.ss1) st.ss1_low = 1'b1;
      if (!bus.ss0 && !bus.ss1) st.both_low = 1'b1;
      if (bus.done) begin
        st.lat     = k;
        st.timeout = 1'b0;
        break;
      end
      if (k == inject_at) begin
        bus.start   = 1'b1;
        bus.sel     = ~sel;
        bus.tx_data = ~tx;
      end
    end
  endtask

  task automatic frame_and_check(input string tag, input logic sel, input logic [7:0] tx,
                                 input logic [7:0] r0, input logic [7:0] r1,
                                 input logic [7:0] exp_rx, input int inject_at);
    stat_t st;
    run_frame(sel, tx, r0, r1, inject_at, st);
    m_slv[sel] = tx;
    check({tag, " timeout"},   32'(st.timeout), 32'd0);
    check({tag, " latency"},   32'(st.lat), 32'(LAT));
    check({tag, " rises"},     32'(st.rises), 32'd8);
    check({tag, " rx_data"},   32'(bus.rx_data), 32'(exp_rx));
    check({tag, " slv0_rx"},   32'(bus.slv0_rx_data), 32'(m_slv[0]));
    check({tag, " slv1_rx"},   32'(bus.slv1_rx_data), 32'(m_slv[1]));
    check({tag, " slv0_vld"},  32'(st.v0), 32'(!sel));
    check({tag, " slv1_vld"},  32'(st.v1), 32'(sel));
    check({tag, " ss0_used"},  32'(st.ss0_low), 32'(!sel));
    check({tag, " ss1_used"},  32'(st.ss1_low), 32'(sel));
    check({tag, " ss_both"},   32'(st.both_low), 32'd0);
    check({tag, " ss_gap"},    32'(st.gap_ok), 32'd1);
  endtask

  // Count done / rx_valid pulses over a quiet window.
  task automatic quiet_window(input string tag, input int cycles);
    int d, v;
    d = 0;
    v = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (bus.done) d++;
      if (bus.slv0_rx_valid || bus.slv1_rx_valid) v++;
    end
    check({tag, " extra_done"},  32'(d), 32'd0);
    check({tag, " extra_valid"}, 32'(v), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [4];
    int   rises;
    bit   hit;
    logic prev_sclk;

    vecs[0] = '{sel: 1'b0, tx: 8'hAA, r0: 8'h3C, r1: 8'h00, exp_rx: 8'h3C};
    vecs[1] = '{sel: 1'b1, tx: 8'h55, r0: 8'h11, r1: 8'hC3, exp_rx: 8'hC3};
    vecs[2] = '{sel: 1'b0, tx: 8'h01, r0: 8'h5A, r1: 8'hA5, exp_rx: 8'h5A};
    vecs[3] = '{sel: 1'b0, tx: 8'h80, r0: 8'h81, r1: 8'h7E, exp_rx: 8'h81};

    bus.start        = 1'b0;
    bus.sel          = 1'b0;
    bus.tx_data      = 8'h00;
    bus.slv0_tx_data = 8'h00;
    bus.slv1_tx_data = 8'h00;
    m_slv[0]         = 8'h00;
    m_slv[1]         = 8'h00;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst sclk",    32'(bus.sclk), 32'd0);
    check("rst mosi",    32'(bus.mosi), 32'd0);
    check("rst ss0",     32'(bus.ss0), 32'd1);
    check("rst ss1",     32'(bus.ss1), 32'd1);
    check("rst busy",    32'(bus.busy), 32'd0);
    check("rst done",    32'(bus.done), 32'd0);
    check("rst rx_data", 32'(bus.rx_data), 32'd0);
    check("rst slv0_rx", 32'(bus.slv0_rx_data), 32'd0);
    check("rst slv1_rx", 32'(bus.slv1_rx_data), 32'd0);
    check("rst valid",   32'(bus.slv0_rx_valid | bus.slv1_rx_valid), 32'd0);
    rst = 1'b1;

    // Directed table; frames run back-to-back (next start in the cycle after done).
    for (int i = 0; i < 4; i++)
      frame_and_check($sformatf("vec%0d", i), vecs[i].sel, vecs[i].tx, vecs[i].r0,
                      vecs[i].r1, vecs[i].exp_rx, -1);

    // Start while busy: a second request mid-frame must be ignored.
    frame_and_check("busy", 1'b0, 8'h96, 8'h69, 8'hFF, 8'h69, 10);
    quiet_window("busy", 45);
    check("busy rx_hold",   32'(bus.rx_data), 32'h69);
    check("busy slv0_hold", 32'(bus.slv0_rx_data), 32'h96);
    check("busy ss_idle",   32'({bus.ss0, bus.ss1}), 32'b11);

    // Reset mid-frame after 4 sclk rises.
    @(negedge clk);
    bus.sel          = 1'b1;
    bus.tx_data      = 8'hE7;
    bus.slv1_tx_data = 8'h3A;
    bus.start        = 1'b1;
    prev_sclk        = bus.sclk;
    rises            = 0;
    hit              = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.sclk && !prev_sclk) rises++;
      prev_sclk = bus.sclk;
      if (rises == 4) begin
        hit = 1'b1;
        break;
      end
    end
    check("midrst reached", 32'(hit), 32'd1);
    rst = 1'b0;
    #1;
    m_slv[0] = 8'h00;
    m_slv[1] = 8'h00;
    check("midrst sclk",    32'(bus.sclk), 32'd0);
    check("midrst mosi",    32'(bus.mosi), 32'd0);
    check("midrst ss",      32'({bus.ss0, bus.ss1}), 32'b11);
    check("midrst busy",    32'(bus.busy), 32'd0);
    check("midrst done",    32'(bus.done), 32'd0);
    check("midrst rx_data", 32'(bus.rx_data), 32'd0);
    check("midrst slv1_rx", 32'(bus.slv1_rx_data), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    quiet_window("midrst", 45);
    frame_and_check("after_rst", 1'b1, 8'hF0, 8'h12, 8'h34, 8'h34, -1);

    // Random frames against the reference model.
    for (int i = 0; i < 8; i++) begin
      logic       rs;
      logic [7:0] rt, r0, r1;
      rs = 1'($urandom_range(0, 1));
      rt = 8'($urandom);
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      frame_and_check($sformatf("rnd%0d", i), rs, rt, r0, r1, rs ? r1 : r0, -1);
    end

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_master_slave.md
Name: spi_master_slave

Overview:
Self-contained SPI link: one SPI master (mode 0, MSB first, 8-bit frames) driving two SPI slaves over shared sclk/mosi, with one active-low select per slave. The host side issues a byte to a chosen slave and receives that slave's reply byte in the same frame. The serial lines are exported as outputs for observation. Used as a loopback/verification fixture and as a reference for on-chip SPI peripherals.

Parameters:
SCLK_HALF, 2, clk cycles per sclk half-period; legal range 2 to 255.

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  reset, asynchronous, active-low
start  in  1  single-cycle request; accepted only when busy=0
sel  in  1  target slave (0 = slave0, 1 = slave1); latched on accept
tx_data  in  8  byte sent by master; latched on accept
rx_data  out  8  byte received by master; updated with done
busy  out  1  high from accept through the done cycle
done  out  1  one-cycle pulse at end of frame
slv0_tx_data  in  8  slave0 reply byte; sampled on ss0 falling edge
slv1_tx_data  in  8  slave1 reply byte; sampled on ss1 falling edge
slv0_rx_data  out  8  last byte received by slave0
slv0_rx_valid  out  1  one-cycle pulse when slave0 completes a byte
slv1_rx_data  out  8  last byte received by slave1
slv1_rx_valid  out  1  one-cycle pulse when slave1 completes a byte
sclk  out  1  serial clock (idle low)
mosi  out  1  master serial out
miso  out  1  selected slave's serial out (muxed, no tristate)
ss0  out  1  slave0 select, active-low
ss1  out  1  slave1 select, active-low

Behaviour:
- Reset values (rst=0, asynchronous): sclk=0, mosi=0, ss0=ss1=1, busy=0, done=0, rx_data=0, slave rx_data=0, rx_valid=0, all shift registers and counters cleared, FSM=IDLE.
- Master FSM states:
  - IDLE: on start=1, latch tx_data and sel, then go to SETUP.
  - SETUP: the selected ss goes low and mosi=tx_data[7], held for SCLK_HALF cycles.
  - XFER: 16 half-periods of SCLK_HALF cycles each; sclk toggles at each half-period boundary (8 rising edges).
  - HOLD: sclk low, ss still low, for SCLK_HALF cycles.
  - DONE: ss high, done=1, rx_data updated, for 1 cycle, then IDLE.
- Latency: done is high in the cycle 18*SCLK_HALF+1 clocks after the edge that accepts start (37 clocks at default).
- Mode 0 timing:
  - Master samples miso in the clk cycle it raises sclk.
  - Master drives the next mosi bit in the cycle it lowers sclk.
  - After the 8th fall, no bit is driven.
- start while busy=1 is ignored; the in-flight frame is unaffected.
- Only the latched slave's ss is ever low; ss0 and ss1 are never low simultaneously.
- Slave (identical per instance, synchronous to clk):
  - Registers sclk and ss once for edge detection.
  - On ss falling edge: load reply byte; miso_i = bit7; clear bit counter.
  - On sclk rise with ss low: shift in mosi, increment count.
  - On the 8th rise: rx_data <= assembled byte, rx_valid pulse 1 cycle.
  - On sclk fall with ss low: shift out next bit.
  - ss high: shifting halted; miso_i=0; rx_data holds.
  - ss rising before 8 bits: partial byte discarded, no rx_valid.
- miso = ss0 low ? slave0 miso_i : ss1 low ? slave1 miso_i : 0.
- Reset asserted mid-frame: everything returns to reset values immediately; no done, no rx_valid.

Decomposition:
- Shared package spi_pkg holds the master FSM state enum (IDLE, SETUP, XFER, HOLD, DONE) and the byte-width constant (8).
- One sub-module spi_slave_if, instantiated twice.
- Master logic and the miso mux live in the top module.

Test Plan:
- Reset: hold rst=0 for 3 cycles -> sclk=0, ss0=ss1=1, busy=0, all rx outputs 0.
- Transfer to slave0: slv0_tx_data=8'h3C, start with sel=0, tx_data=8'hAA.
  - Required: ss0 low for the frame while ss1 stays high; exactly 8 sclk rises.
  - Required: slv0_rx_data=8'hAA with one slv0_rx_valid pulse.
  - Required: done 37 cycles after accept, with rx_data=8'h3C.
- Transfer to slave1: slv1_tx_data=8'hC3, sel=1, tx_data=8'h55.
  - Required: slv1_rx_data=8'h55 and rx_data=8'hC3.
  - Required: slv0_rx_data still 8'hAA and no slv0_rx_valid.
- Start while busy: second start pulse mid-frame -> ignored; only one done pulse; rx values unchanged from the first frame.
- Reset mid-frame: assert rst after 4 sclk rises -> immediate idle lines, no done, no rx_valid. A following full transfer of 8'hF0 completes correctly.
- Back-to-back: start issued the cycle after done, for 8'h01 then 8'h80 -> both bytes received correctly by the slave; ss deasserted for at least 1 cycle between frames.
